// File: rtl/count_seq_pkg.sv
// Shared types and code helpers for the even-code count sequence monitor.
package count_seq_pkg;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} seq_state_e;

  localparam logic [3:0] S0 = 4'b0000;
  localparam logic [3:0] S1 = 4'b0010;
  localparam logic [3:0] S2 = 4'b0100;
  localparam logic [3:0] S3 = 4'b0110;

  function automatic logic code_is_legal(input logic [3:0] c);
    return (c == S0) || (c == S1) || (c == S2) || (c == S3);
  endfunction

  function automatic logic [1:0] code_to_index(input logic [3:0] c);
    return c[2:1];
  endfunction

endpackage

// File: rtl/state_sync_filter.sv
// Two-register sample pipeline; a sample is stable once both stages agree.
module state_sync_filter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic         stable_o,
  output logic [W-1:0] sample_o
);

  logic [W-1:0] r1_q, r2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r1_q <= '0;
      r2_q <= '0;
    end else begin
      r1_q <= d_i;
      r2_q <= r1_q;
    end
  end

  assign stable_o = (r1_q == r2_q);
  assign sample_o = r2_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Count-sequence monitor: step decode, lock tracking, fault and stall flags.
module count_seq_monitor
  import count_seq_pkg::*;
#(
  parameter int LOCK_COUNT  = 3,
  parameter int STALL_W     = 28,
  parameter int STALL_LIMIT = 150000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] state_in,
  output logic [1:0] index,
  output logic       step_valid,
  output logic       dir_up,
  output logic       locked,
  output logic       fault,
  output logic       stall,
  output logic [7:0] step_count,
  output logic [3:0] error_count
);

  localparam logic [STALL_W-1:0] LIMIT  = STALL_W'(STALL_LIMIT);
  localparam logic [3:0]         LOCK_N = 4'(LOCK_COUNT);

  logic       stable;
  logic [3:0] sample;

  state_sync_filter #(.W(4)) u_filt (
    .clock    (clock),
    .reset    (reset),
    .d_i      (state_in),
    .stable_o (stable),
    .sample_o (sample)
  );

  seq_state_e         state_q;
  logic [3:0]         prev_q, run_q;
  logic [STALL_W-1:0] timer_q, timer_d;
  logic [1:0]         index_q;
  logic               step_valid_q, dir_up_q, locked_q, fault_q, stall_q;
  logic [7:0]         step_count_q;
  logic [3:0]         error_count_q;

  logic       evt, legal, is_up, fault_w, accept_w;
  logic [1:0] new_idx, delta;
  logic [3:0] run_nxt;

  assign evt     = stable && (sample != prev_q);
  assign legal   = code_is_legal(sample);
  assign new_idx = code_to_index(sample);
  assign delta   = new_idx - index_q;
  assign is_up   = (delta == 2'd1);
  assign run_nxt = ((run_q != 4'd0) && (is_up == dir_up_q)) ? run_q + 4'd1 : 4'd1;

  // In FAULT, prev_q holds the faulting code, so evt means "differs from it".
  always_comb begin
    fault_w  = 1'b0;
    accept_w = 1'b0;
    unique case (state_q)
      IDLE: begin
        fault_w  = stable && !legal;
        accept_w = stable && legal;
      end
      ACQUIRE, LOCKED: begin
        fault_w  = evt && (!legal || (delta == 2'd2));
        accept_w = evt && !fault_w;
      end
      FAULT:   accept_w = evt && legal;
      default: ;
    endcase
    timer_d = timer_q;
    if (fault_w || accept_w)
      timer_d = '0;
    else if ((state_q != IDLE) && (timer_q != LIMIT))
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_q        <= S0;
      run_q         <= '0;
      timer_q       <= '0;
      index_q       <= '0;
      step_valid_q  <= 1'b0;
      dir_up_q      <= 1'b1;
      locked_q      <= 1'b0;
      fault_q       <= 1'b0;
      stall_q       <= 1'b0;
      step_count_q  <= '0;
      error_count_q <= '0;
    end else begin
      step_valid_q <= 1'b0;
      timer_q      <= timer_d;
      stall_q      <= (timer_d == LIMIT);
      if (fault_w) begin
        state_q  <= FAULT;
        prev_q   <= sample;
        fault_q  <= 1'b1;
        locked_q <= 1'b0;
        run_q    <= '0;
        if (error_count_q != 4'hF) error_count_q <= error_count_q + 4'd1;
      end else if (accept_w) begin
        prev_q  <= sample;
        index_q <= new_idx;
        if ((state_q == IDLE) || (state_q == FAULT)) begin
          state_q <= ACQUIRE;
          fault_q <= 1'b0;
        end else begin
          step_valid_q <= 1'b1;
          dir_up_q     <= is_up;
          step_count_q <= step_count_q + 8'd1;
          if (state_q == LOCKED) begin
            if (is_up != dir_up_q) begin
              run_q    <= 4'd1;
              state_q  <= ACQUIRE;
              locked_q <= 1'b0;
            end
          end else begin
            run_q <= run_nxt;
            if (run_nxt >= LOCK_N) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign index       = index_q;
  assign step_valid  = step_valid_q;
  assign dir_up      = dir_up_q;
  assign locked      = locked_q;
  assign fault       = fault_q;
  assign stall       = stall_q;
  assign step_count  = step_count_q;
  assign error_count = error_count_q;

endmodule
